// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the 1100 stimulus generator and its golden tracker.
package seq_gen_pkg;

    // Main transmitter FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    // Golden detector states: number of target bits currently matched
    typedef enum logic [1:0] {
        T0   = 2'd0,
        T1   = 2'd1,
        T11  = 2'd2,
        T110 = 2'd3
    } trk_state_e;

    // Sequence the downstream detectors look for, MSB received first
    localparam logic [3:0] TARGET_SEQ = 4'b1100;

    // Hit counter width and its saturation value
    localparam int         HIT_W       = 8;
    localparam logic [7:0] HIT_CNT_MAX = 8'd255;

endpackage

// File: rtl/seq_1100_tracker.sv
// Golden non-overlapping Mealy 1100 tracker: produces expect_z for the bit on
// the line and counts hits. Also usable standalone as a bench scoreboard.
module seq_1100_tracker
    import seq_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             x,
    output logic             expect_z,
    output logic [HIT_W-1:0] hit_cnt
);

    trk_state_e       state_q, state_d;
    logic [HIT_W-1:0] hit_q, hit_d;
    logic             z;

    // Next tracker state and Mealy output for the current line bit
    always_comb begin
        state_d = state_q;
        z       = 1'b0;
        if (adv) begin
            case (state_q)
                T0:   state_d = (x == TARGET_SEQ[3]) ? T1 : T0;
                T1:   state_d = (x == TARGET_SEQ[2]) ? T11 : T0;
                T11:  state_d = (x == TARGET_SEQ[1]) ? T110 : T11;
                T110: begin
                    if (x == TARGET_SEQ[0]) begin
                        // Full match: report it and restart from scratch
                        z       = 1'b1;
                        state_d = T0;
                    end else begin
                        // "1101": the trailing 1 is a fresh first bit
                        state_d = T1;
                    end
                end
                default: state_d = T0;
            endcase
        end

        hit_d = hit_q;
        if (clr) begin
            state_d = T0;
            hit_d   = '0;
        end else if (z && (hit_q != HIT_CNT_MAX)) begin
            hit_d = hit_q + HIT_W'(1);
        end
    end

    // Tracker state and saturating hit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
        end
    end

    assign expect_z = z;
    assign hit_cnt  = hit_q;

endmodule

// File: rtl/seq_1100_stim_gen.sv
// Serial pattern transmitter for 1100 detector benches. Sends a latched
// pattern MSB-first, optionally repeated with forced-zero gaps, and tracks
// where a non-overlapping Mealy 1100 detector must fire.
module seq_1100_stim_gen
    import seq_gen_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int RPT_W   = 8,
    parameter int GAP_W   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [MAX_LEN-1:0]             pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   len,
    input  logic [RPT_W-1:0]               repeat_n,
    input  logic [GAP_W-1:0]               gap,
    output logic                           x,
    output logic                           x_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           expect_z,
    output logic [HIT_W-1:0]               hit_cnt,
    output logic                           bad_cfg
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    fsm_state_e           state_q, state_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [RPT_W-1:0]     rpt_q, rpt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [MAX_LEN-1:0]   pattern_q, pattern_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 x_q, x_d;
    logic                 bad_cfg_q, bad_cfg_d;
    logic                 accept;
    logic                 len_legal;

    // Bit select with an index that may be wider than needed
    function automatic logic bit_at(input logic [MAX_LEN-1:0] p,
                                    input logic [LEN_W-1:0]   i);
        return |(p & (MAX_LEN'(1) << i));
    endfunction

    assign len_legal = (len != '0) && (len <= LEN_W'(MAX_LEN));

    // Transmitter next-state: x_d is the bit that will be on the line next cycle
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rpt_d     = rpt_q;
        gap_cnt_d = gap_cnt_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        gap_d     = gap_q;
        x_d       = 1'b0;
        bad_cfg_d = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_legal) begin
                        accept    = 1'b1;
                        pattern_d = pattern;
                        len_d     = len;
                        gap_d     = gap;
                        rpt_d     = (repeat_n == '0) ? RPT_W'(1) : repeat_n;
                        idx_d     = len - LEN_W'(1);
                        x_d       = bit_at(pattern, len - LEN_W'(1));
                        state_d   = ST_SEND;
                    end else begin
                        bad_cfg_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - LEN_W'(1);
                    x_d   = bit_at(pattern_q, idx_q - LEN_W'(1));
                end else if (rpt_q > RPT_W'(1)) begin
                    if (gap_q != '0) begin
                        gap_cnt_d = gap_q;
                        state_d   = ST_GAP;
                    end else begin
                        // Back-to-back repetition: restart at the MSB
                        rpt_d = rpt_q - RPT_W'(1);
                        idx_d = len_q - LEN_W'(1);
                        x_d   = bit_at(pattern_q, len_q - LEN_W'(1));
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    rpt_d   = rpt_q - RPT_W'(1);
                    idx_d   = len_q - LEN_W'(1);
                    x_d     = bit_at(pattern_q, len_q - LEN_W'(1));
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transmitter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rpt_q     <= '0;
            gap_cnt_q <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            x_q       <= 1'b0;
            bad_cfg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rpt_q     <= rpt_d;
            gap_cnt_q <= gap_cnt_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            x_q       <= x_d;
            bad_cfg_q <= bad_cfg_d;
        end
    end

    // Gap zeros are real line bits, so the tracker advances in GAP too
    seq_1100_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .adv      ((state_q == ST_SEND) || (state_q == ST_GAP)),
        .x        (x_q),
        .expect_z (expect_z),
        .hit_cnt  (hit_cnt)
    );

    assign x       = x_q;
    assign x_valid = (state_q == ST_SEND);
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign bad_cfg = bad_cfg_q;

endmodule

// File: tb/tb_seq_1100_stim_gen.sv
// Self-checking bench for seq_1100_stim_gen: a per-cycle reference built from
// the line contents of each accepted transaction, plus directed literal checks.
module tb_seq_1100_stim_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pattern;
    logic [5:0]  len;
    logic [7:0]  repeat_n;
    logic [3:0]  gap;
    logic        x, x_valid, busy, done, expect_z, bad_cfg;
    logic [7:0]  hit_cnt;

    int checks = 0;
    int errors = 0;

    seq_1100_stim_gen #(.MAX_LEN(32), .RPT_W(8), .GAP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .len      (len),
        .repeat_n (repeat_n),
        .gap      (gap),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done),
        .expect_z (expect_z),
        .hit_cnt  (hit_cnt),
        .bad_cfg  (bad_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       x;
        logic       xv;
        logic       busy;
        logic       done;
        logic       z;
        logic [7:0] hit;
        logic       bad;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] hit_hold = 8'd0;
    bit         bad_next = 1'b0;
    int         cyc_no   = 0;

    // Expand an accepted transaction into the per-cycle outputs it must produce
    function automatic void build(input logic [31:0] p, input int ln,
                                  input int rp, input int gp);
        bit   line[$];
        bit   vld[$];
        int   r_eff;
        int   since;
        int   hits;
        logic [3:0] last;
        exp_t e;
        r_eff = (rp == 0) ? 1 : rp;
        for (int r = 0; r < r_eff; r++) begin
            for (int i = ln - 1; i >= 0; i--) begin
                line.push_back(p[i]);
                vld.push_back(1'b1);
            end
            if (r < r_eff - 1)
                for (int g = 0; g < gp; g++) begin
                    line.push_back(1'b0);
                    vld.push_back(1'b0);
                end
        end
        since = 0;
        hits  = 0;
        last  = 4'b0000;
        foreach (line[t]) begin
            e      = '0;
            e.x    = line[t];
            e.xv   = vld[t];
            e.busy = 1'b1;
            e.hit  = (hits > 255) ? 8'd255 : 8'(hits);
            last   = {last[2:0], line[t]};
            since++;
            // Non-overlapping: only bits after the previous hit may form a match
            if (since >= 4 && last == 4'b1100) begin
                e.z   = 1'b1;
                hits++;
                since = 0;
                last  = 4'b0000;
            end
            exp_q.push_back(e);
        end
        e      = '0;
        e.busy = 1'b1;
        e.done = 1'b1;
        e.hit  = (hits > 255) ? 8'd255 : 8'(hits);
        exp_q.push_back(e);
        hit_hold = e.hit;
    endfunction

    // Per-cycle compare against the model; also decides what the next edge accepts
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (rst) begin
                exp_q.delete();
                hit_hold = 8'd0;
                bad_next = 1'b0;
                e = '0;
            end else begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else begin
                    e = '0;
                    e.hit = hit_hold;
                end
                e.bad    = bad_next;
                bad_next = 1'b0;
            end
            a = '{x: x, xv: x_valid, busy: busy, done: done, z: expect_z,
                  hit: hit_cnt, bad: bad_cfg};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_%0d outputs: got x=%b xv=%b busy=%b done=%b z=%b hit=%0d bad=%b, want x=%b xv=%b busy=%b done=%b z=%b hit=%0d bad=%b",
                         cyc_no, a.x, a.xv, a.busy, a.done, a.z, a.hit, a.bad,
                         e.x, e.xv, e.busy, e.done, e.z, e.hit, e.bad);
            end
            if (!rst && !e.busy && start) begin
                if (len == 6'd0 || len > 6'd32) bad_next = 1'b1;
                else build(pattern, int'(len), int'(repeat_n), int'(gap));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called in an idle cycle just after a rising edge; returns the same way.
    task automatic run_txn(input logic [31:0] p, input int ln, input int rp,
                           input int gp, input bit stray, input int exp_done,
                           input bit chk_hits, input int exp_hits);
        int   r_eff;
        int   total;
        int   cyc;
        bit   seen;
        logic [7:0] hits_at_done;
        r_eff = (rp == 0) ? 1 : rp;
        total = r_eff * ln + (r_eff - 1) * gp;
        start = 1'b1; pattern = p; len = 6'(ln); repeat_n = 8'(rp); gap = 4'(gp);
        @(posedge clk); #1;
        seen = 1'b0;
        hits_at_done = 8'd0;
        for (cyc = 1; cyc <= total + 20; cyc++) begin
            if (stray && cyc <= total && $urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                pattern  = $urandom;
                len      = 6'($urandom_range(0, 40));
                repeat_n = 8'($urandom_range(0, 255));
                gap      = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                hits_at_done = hit_cnt;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (!seen || cyc != exp_done) begin
            errors++;
            $display("FAIL done_cycle len=%0d R=%0d gap=%0d: got %0d (seen=%0d), want %0d",
                     ln, rp, gp, cyc, seen, exp_done);
        end
        if (chk_hits) begin
            checks++;
            if (hits_at_done !== 8'(exp_hits)) begin
                errors++;
                $display("FAIL hit_cnt len=%0d: got %0d, want %0d", ln, hits_at_done, exp_hits);
            end
        end
        $display("txn pattern=%h len=%0d R=%0d gap=%0d done_cycle=%0d hit_cnt=%0d",
                 p, ln, rp, gp, cyc, hits_at_done);
        if (seen) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic bad_start(input int ln);
        start = 1'b1; len = 6'(ln); pattern = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (!(bad_cfg === 1'b1 && busy === 1'b0)) begin
            errors++;
            $display("FAIL bad_cfg len=%0d: got bad_cfg=%b busy=%b, want bad_cfg=1 busy=0",
                     ln, bad_cfg, busy);
        end
        $display("txn illegal start len=%0d bad_cfg=%b", ln, bad_cfg);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid(input int after);
        start = 1'b1; pattern = $urandom; len = 6'd32; repeat_n = 8'd3; gap = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (after) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({x, x_valid, busy, done, expect_z, hit_cnt, bad_cfg} !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid: got x=%b xv=%b busy=%b done=%b z=%b hit=%0d bad=%b, want all 0",
                     x, x_valid, busy, done, expect_z, hit_cnt, bad_cfg);
        end
        $display("txn reset after %0d cycles", after);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic ignored_start;
        int cyc;
        bit seen;
        logic [7:0] h;
        start = 1'b1; pattern = 32'hC; len = 6'd4; repeat_n = 8'd1; gap = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; pattern = 32'hFFFF_FFFF; len = 6'd32; repeat_n = 8'd5; gap = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        h = 8'd0;
        for (cyc = 3; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                h = hit_cnt;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen || cyc != 5 || h !== 8'd1) begin
            errors++;
            $display("FAIL ignored_start: got done_cycle=%0d seen=%0d hit=%0d, want 5 1 1",
                     cyc, seen, h);
        end
        $display("txn start-during-send done_cycle=%0d hit_cnt=%0d", cyc, h);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; len = '0; repeat_n = '0; gap = '0;
        @(negedge clk);
        checks++;
        if ({x, x_valid, busy, done, expect_z, hit_cnt, bad_cfg} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: got x=%b busy=%b hit=%0d, want all 0", x, busy, hit_cnt);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios with hand-computed done cycle and hit count
        run_txn(32'hC,       4,  1, 0, 1'b0, 5,  1'b1, 1);
        run_txn(32'h19B32,   17, 1, 0, 1'b0, 18, 1'b1, 3);
        run_txn(32'h6,       3,  3, 2, 1'b0, 14, 1'b1, 2);
        run_txn(32'h1C,      5,  1, 0, 1'b0, 6,  1'b1, 1);
        run_txn(32'hFF,      8,  0, 0, 1'b0, 9,  1'b1, 0);
        run_txn(32'hC,       4,  2, 0, 1'b0, 9,  1'b1, 2);
        bad_start(0);
        bad_start(33);
        ignored_start();
        reset_mid(4);
        run_txn(32'hC,       4,  1, 0, 1'b0, 5,  1'b1, 1);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            int kind;
            int ln;
            int rp;
            int gp;
            int r_eff;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                bad_start(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63));
            end else if (kind == 1) begin
                reset_mid($urandom_range(1, 10));
            end else begin
                ln = $urandom_range(1, 32);
                rp = $urandom_range(0, 4);
                gp = $urandom_range(0, 15);
                r_eff = (rp == 0) ? 1 : rp;
                run_txn($urandom & $urandom_range(0, 1) ? 32'hCCCC_CCCC ^ $urandom : $urandom,
                        ln, rp, gp, 1'b1, r_eff * ln + (r_eff - 1) * gp + 1, 1'b0, 0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
